// File: rtl/line_raster_pkg.sv
// Shared types for the line rasteriser: FSM encoding, coordinate type and
// the command record that travels through the command FIFO.
package line_raster_pkg;

    localparam int CW_DEF = 10;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SETUP = 2'd1;
    localparam logic [1:0] S_PLOT  = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = S_IDLE,
        SETUP = S_SETUP,
        PLOT  = S_PLOT
    } state_e;

    typedef logic [CW_DEF-1:0] coord_t;

    typedef struct packed {
        coord_t     x0;
        coord_t     y0;
        coord_t     x1;
        coord_t     y1;
        logic [7:0] color;
    } cmd_t;

endpackage

// File: rtl/line_cmd_fifo.sv
// Synchronous command FIFO; one extra pointer bit separates full from empty.
module line_cmd_fifo
    import line_raster_pkg::*;
#(
    parameter type T     = cmd_t,
    parameter int  DEPTH = 4
) (
    input  logic clk25,
    input  logic rst,
    input  logic push,
    input  logic pop,
    input  T     din,
    output T     dout,
    output logic full,
    output logic empty
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] PTR_ONE = 1;

    logic [PW:0] wr_ptr;
    logic [PW:0] rd_ptr;
    T            mem [DEPTH];

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PW] != rd_ptr[PW]) &&
                   (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign dout  = mem[rd_ptr[PW-1:0]];

    always_ff @(posedge clk25 or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop && !empty)
                rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk25) begin
        if (push && !full)
            mem[wr_ptr[PW-1:0]] <= din;
    end

endmodule

// File: rtl/line_raster.sv
// Queued Bresenham line drawer writing 8-bit pixels into a 16-bit SRAM,
// two pixels per word, driving the shared bus only while granted.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   S_IDLE  | waiting for a command; pops the FIFO head into x_r/y_r
//   S_SETUP | derives step directions, |dx|, -|dy| and the initial error
//   S_PLOT  | one pixel per granted cycle until the endpoint is written
module line_raster
    import line_raster_pkg::*;
#(
    parameter int CW         = 10,
    parameter int H_RES      = 640,
    parameter int V_RES      = 480,
    parameter int STRIDE     = 320,
    parameter int AW         = 20,
    parameter int FIFO_DEPTH = 4
) (
    input  logic          clk25,
    input  logic          rst,
    input  logic          enable,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [CW-1:0] cmd_x0,
    input  logic [CW-1:0] cmd_y0,
    input  logic [CW-1:0] cmd_x1,
    input  logic [CW-1:0] cmd_y1,
    input  logic [7:0]    cmd_color,
    output logic          busy,
    output logic [AW-1:0] SRAM_ADDR,
    output logic [15:0]   SRAM_DQ,
    output logic          SRAM_CE_N,
    output logic          SRAM_OE_N,
    output logic          SRAM_WE_N,
    output logic          SRAM_UB_N,
    output logic          SRAM_LB_N
);

    localparam int SW = CW + 3;
    localparam logic [CW:0]   H_LIM    = (CW+1)'(H_RES);
    localparam logic [CW:0]   V_LIM    = (CW+1)'(V_RES);
    localparam logic [AW-1:0] STRIDE_A = AW'(STRIDE);
    localparam logic [CW-1:0] ONE_C    = 1;

    typedef logic signed [SW-1:0] sval_t;

    typedef struct packed {
        logic [CW-1:0] x0;
        logic [CW-1:0] y0;
        logic [CW-1:0] x1;
        logic [CW-1:0] y1;
        logic [7:0]    color;
    } lcmd_t;

    lcmd_t cmd_in;
    lcmd_t head;
    logic  fifo_full;
    logic  fifo_empty;
    logic  push;
    logic  pop;

    logic [1:0]    state;
    logic [CW-1:0] x_r, y_r, x1_r, y1_r;
    logic [7:0]    col_r;
    logic          sx_r, sy_r;
    sval_t         dx_r, dy_r, err_r;

    logic          wr_val;
    logic [AW-1:0] addr_r;
    logic [15:0]   dq_r;
    logic          lb_n_r, ub_n_r;

    assign cmd_in    = '{x0: cmd_x0, y0: cmd_y0, x1: cmd_x1, y1: cmd_y1, color: cmd_color};
    assign cmd_ready = !fifo_full;
    assign push      = cmd_valid && !fifo_full;
    assign pop       = (state == S_IDLE) && !fifo_empty;
    assign busy      = !fifo_empty || (state != S_IDLE);

    line_cmd_fifo #(
        .T     (lcmd_t),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk25 (clk25),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (cmd_in),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    logic [CW-1:0] adx, ady;
    sval_t         e2, err_step;
    logic          step_x, step_y, in_view, at_end;
    logic [CW-1:0] x_next, y_next;
    logic [AW-1:0] pix_addr;

    assign adx      = (x1_r >= x_r) ? (x1_r - x_r) : (x_r - x1_r);
    assign ady      = (y1_r >= y_r) ? (y1_r - y_r) : (y_r - y1_r);
    assign e2       = err_r <<< 1;
    assign step_x   = (e2 >= dy_r);
    assign step_y   = (e2 <= dx_r);
    assign err_step = err_r + (step_x ? dy_r : sval_t'(0)) + (step_y ? dx_r : sval_t'(0));
    assign x_next   = sx_r ? (x_r + ONE_C) : (x_r - ONE_C);
    assign y_next   = sy_r ? (y_r + ONE_C) : (y_r - ONE_C);
    assign in_view  = ({1'b0, x_r} < H_LIM) && ({1'b0, y_r} < V_LIM);
    assign at_end   = (x_r == x1_r) && (y_r == y1_r);
    assign pix_addr = AW'(y_r) * STRIDE_A + AW'(x_r[CW-1:1]);

    always_ff @(posedge clk25 or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            x_r    <= '0;
            y_r    <= '0;
            x1_r   <= '0;
            y1_r   <= '0;
            col_r  <= '0;
            sx_r   <= 1'b0;
            sy_r   <= 1'b0;
            dx_r   <= '0;
            dy_r   <= '0;
            err_r  <= '0;
            wr_val <= 1'b0;
            addr_r <= '0;
            dq_r   <= '0;
            lb_n_r <= 1'b1;
            ub_n_r <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    // A finished line's last write stays pending until it has seen a granted cycle
                    if (enable)
                        wr_val <= 1'b0;
                    if (!fifo_empty) begin
                        x_r   <= head.x0;
                        y_r   <= head.y0;
                        x1_r  <= head.x1;
                        y1_r  <= head.y1;
                        col_r <= head.color;
                        state <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (enable)
                        wr_val <= 1'b0;
                    sx_r  <= (x1_r >= x_r);
                    sy_r  <= (y1_r >= y_r);
                    dx_r  <= sval_t'(adx);
                    dy_r  <= -sval_t'(ady);
                    err_r <= sval_t'(adx) - sval_t'(ady);
                    state <= S_PLOT;
                end
                S_PLOT: begin
                    if (enable) begin
                        wr_val <= in_view;
                        if (in_view) begin
                            addr_r <= pix_addr;
                            dq_r   <= {col_r, col_r};
                            lb_n_r <= x_r[0];
                            ub_n_r <= ~x_r[0];
                        end
                        if (at_end) begin
                            state <= S_IDLE;
                        end else begin
                            if (step_x)
                                x_r <= x_next;
                            if (step_y)
                                y_r <= y_next;
                            err_r <= err_step;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    logic drive;
    assign drive = enable && wr_val;

    // Write strobe follows the clock so WE_N is low only in the second half-cycle
    assign SRAM_ADDR = drive ? addr_r : {AW{1'bz}};
    assign SRAM_DQ   = drive ? dq_r   : {16{1'bz}};
    assign SRAM_CE_N = drive ? 1'b0   : 1'bz;
    assign SRAM_OE_N = drive ? 1'b1   : 1'bz;
    assign SRAM_WE_N = drive ? clk25  : 1'bz;
    assign SRAM_UB_N = drive ? ub_n_r : 1'bz;
    assign SRAM_LB_N = drive ? lb_n_r : 1'bz;

endmodule

// File: tb/tb_line_raster.sv
// Bench for line_raster: fixed vectors, random lines against an integer
// Bresenham model, back-pressure with grant toggling, and mid-line reset.
module tb_line_raster;

    logic        clk25 = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [9:0]  cmd_x0 = '0, cmd_y0 = '0, cmd_x1 = '0, cmd_y1 = '0;
    logic [7:0]  cmd_color = '0;
    logic        busy;
    wire  [19:0] sram_addr;
    wire  [15:0] sram_dq;
    wire         sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;

    // Weak pulls make a released bus visible as a distinct level
    pullup   (sram_ce_n);
    pulldown (sram_oe_n);
    pullup   (sram_we_n);
    pullup   (sram_ub_n);
    pullup   (sram_lb_n);

    line_raster dut (
        .clk25     (clk25),
        .rst       (rst),
        .enable    (enable),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_x0    (cmd_x0),
        .cmd_y0    (cmd_y0),
        .cmd_x1    (cmd_x1),
        .cmd_y1    (cmd_y1),
        .cmd_color (cmd_color),
        .busy      (busy),
        .SRAM_ADDR (sram_addr),
        .SRAM_DQ   (sram_dq),
        .SRAM_CE_N (sram_ce_n),
        .SRAM_OE_N (sram_oe_n),
        .SRAM_WE_N (sram_we_n),
        .SRAM_UB_N (sram_ub_n),
        .SRAM_LB_N (sram_lb_n)
    );

    always #20 clk25 = ~clk25;

    typedef struct {
        int x0, y0, x1, y1, col;
        int n_wr, first_addr, last_addr, first_off, last_off, busy_cyc;
        int first_dq, first_lb;
    } vec_t;

    longint exp_q[$];
    longint got_q[$];
    longint saved_q[$];
    int     got_cyc[$];
    int     cyc = 0;
    int     zbad = 0;
    int     passed = 0;
    int     total = 0;

    function automatic longint enc(input longint addr, input longint dq, input longint lb, input longint ub);
        return (addr << 18) | (dq << 2) | (lb << 1) | ub;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic sample();
        @(negedge clk25);
        cyc++;
        if (sram_ce_n == 1'b0) begin
            if (!enable || sram_oe_n !== 1'b1 || sram_we_n !== 1'b0 || sram_lb_n == sram_ub_n)
                zbad++;
            got_q.push_back(enc(longint'(sram_addr), longint'(sram_dq), longint'(sram_lb_n), longint'(sram_ub_n)));
            got_cyc.push_back(cyc);
        end else if (sram_oe_n !== 1'b0 || sram_we_n !== 1'b1 || sram_lb_n !== 1'b1 || sram_ub_n !== 1'b1) begin
            zbad++;
        end
    endtask

    // Reference rasteriser: appends expected visible writes, returns pixel count
    function automatic int model_line(input int x0, input int y0, input int x1, input int y1, input int col);
        int dx, dy, err, e2, sx, sy, x, y, n;
        dx  = (x1 >= x0) ? x1 - x0 : x0 - x1;
        dy  = -((y1 >= y0) ? y1 - y0 : y0 - y1);
        sx  = (x1 >= x0) ? 1 : -1;
        sy  = (y1 >= y0) ? 1 : -1;
        err = dx + dy;
        x = x0; y = y0; n = 0;
        while (1) begin
            n++;
            if (x < 640 && y < 480)
                exp_q.push_back(enc(y * 320 + x / 2, col * 257, x % 2, 1 - x % 2));
            if (x == x1 && y == y1) break;
            e2 = 2 * err;
            if (e2 >= dy) begin err += dy; x += sx; end
            if (e2 <= dx) begin err += dx; y += sy; end
        end
        return n;
    endfunction

    task automatic push_cmd(input int x0, input int y0, input int x1, input int y1, input int col);
        int waited;
        sample();
        cmd_x0 = 10'(x0); cmd_y0 = 10'(y0); cmd_x1 = 10'(x1); cmd_y1 = 10'(y1);
        cmd_color = 8'(col);
        cmd_valid = 1'b1;
        waited = 0;
        while (!cmd_ready && waited < 3000) begin
            sample();
            waited++;
        end
        if (!cmd_ready) check("push_timeout", 0, 1);
        @(posedge clk25);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic compare_writes(input string tag);
        int n;
        check($sformatf("%s_count", tag), got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s_px%0d", tag, i), got_q[i], exp_q[i]);
    endtask

    task automatic run_line(input string tag, input int x0, input int y0, input int x1, input int y1,
                            input int col, output int e_cyc, output int bn, output int npix);
        got_q.delete(); got_cyc.delete(); exp_q.delete();
        npix = model_line(x0, y0, x1, y1, col);
        push_cmd(x0, y0, x1, y1, col);
        e_cyc = cyc;
        bn = 0;
        for (int i = 0; i < 5000; i++) begin
            sample();
            if (busy) bn++;
            else break;
        end
        sample();
        sample();
        compare_writes(tag);
        check($sformatf("%s_busy_cycles", tag), bn, npix + 2);
    endtask

    initial begin
        #20ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl[6];
        int   e, bn, np, pend, acc_next, nrst;
        int   x0, y0, x1, y1;

        tbl[0] = '{5, 7, 5, 7, 'hA5, 1, 2242, 2242, 4, 4, 3, 'hA5A5, 1};
        tbl[1] = '{0, 0, 3, 0, 'h3C, 4, 0, 1, 4, 7, 6, 'h3C3C, 0};
        tbl[2] = '{10, 10, 7, 4, 'h5A, 7, 3205, 1283, 4, 10, 9, 'h5A5A, 0};
        tbl[3] = '{7, 4, 10, 10, 'h5A, 7, 1283, 3205, 4, 10, 9, 'h5A5A, 1};
        tbl[4] = '{0, 0, 4, 4, 'hC3, 5, 0, 1282, 4, 8, 7, 'hC3C3, 0};
        tbl[5] = '{636, 479, 645, 479, 'h77, 4, 153598, 153599, 4, 7, 12, 'h7777, 0};

        // Reset state
        sample();
        sample();
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_ce_released", sram_ce_n, 1);
        check("rst_oe_released", sram_oe_n, 0);
        rst = 1'b0;
        sample();

        // Directed vectors
        for (int t = 0; t < 6; t++) begin
            run_line($sformatf("vec%0d", t), tbl[t].x0, tbl[t].y0, tbl[t].x1, tbl[t].y1,
                     tbl[t].col, e, bn, np);
            check($sformatf("vec%0d_nwr", t), got_q.size(), tbl[t].n_wr);
            check($sformatf("vec%0d_busy_tbl", t), bn, tbl[t].busy_cyc);
            if (got_q.size() > 0) begin
                check($sformatf("vec%0d_first_addr", t), got_q[0] >> 18, tbl[t].first_addr);
                check($sformatf("vec%0d_last_addr", t), got_q[got_q.size()-1] >> 18, tbl[t].last_addr);
                check($sformatf("vec%0d_first_dq", t), (got_q[0] >> 2) & 'hFFFF, tbl[t].first_dq);
                check($sformatf("vec%0d_first_lb", t), (got_q[0] >> 1) & 1, tbl[t].first_lb);
                check($sformatf("vec%0d_first_lat", t), got_cyc[0] - e, tbl[t].first_off);
                check($sformatf("vec%0d_last_lat", t), got_cyc[got_cyc.size()-1] - e, tbl[t].last_off);
            end
            if (t == 1)
                for (int i = 0; i < got_q.size() && i < 4; i++)
                    check($sformatf("horiz_lb%0d", i), (got_q[i] >> 1) & 1, i % 2);
        end

        // Random lines, one at a time, grant held high
        for (int r = 0; r < 25; r++) begin
            x0 = $urandom_range(0, 700);
            y0 = $urandom_range(0, 520);
            if (r % 2 == 0) begin
                x1 = $urandom_range(0, 700);
                y1 = $urandom_range(0, 520);
            end else begin
                x1 = x0 + $urandom_range(0, 40) - 20;
                y1 = y0 + $urandom_range(0, 40) - 20;
                if (x1 < 0) x1 = 0;
                if (y1 < 0) y1 = 0;
            end
            run_line($sformatf("rnd%0d", r), x0, y0, x1, y1, $urandom_range(0, 255), e, bn, np);
        end

        // Back-pressure: FSM holds one stalled line, four more fill the FIFO
        got_q.delete(); got_cyc.delete(); exp_q.delete();
        sample();
        enable = 1'b0;
        np = model_line(20, 100, 60, 112, 'h11);
        np = model_line(1, 1, 9, 3, 'h22);
        np = model_line(100, 50, 95, 60, 'h33);
        np = model_line(638, 2, 642, 2, 'h44);
        np = model_line(3, 470, 3, 482, 'h55);
        np = model_line(300, 300, 310, 290, 'h66);
        push_cmd(20, 100, 60, 112, 'h11);
        for (int i = 0; i < 4; i++) sample();
        push_cmd(1, 1, 9, 3, 'h22);
        push_cmd(100, 50, 95, 60, 'h33);
        push_cmd(638, 2, 642, 2, 'h44);
        check("bp_ready_before_4th", cmd_ready, 1);
        push_cmd(3, 470, 3, 482, 'h55);
        check("bp_ready_full", cmd_ready, 0);
        check("bp_busy", busy, 1);
        sample();
        cmd_x0 = 10'd300; cmd_y0 = 10'd300; cmd_x1 = 10'd310; cmd_y1 = 10'd290; cmd_color = 8'h66;
        cmd_valid = 1'b1;
        nrst = 0;
        for (int i = 0; i < 3; i++) begin
            sample();
            nrst += int'(cmd_ready);
        end
        check("bp_ready_held_low", nrst, 0);
        check("bp_no_write_while_ungranted", got_q.size(), 0);
        pend = 1;
        acc_next = 0;
        for (int i = 0; i < 20000; i++) begin
            sample();
            if (acc_next != 0) begin
                cmd_valid = 1'b0;
                pend = 0;
                acc_next = 0;
            end else if (pend != 0 && cmd_ready) begin
                acc_next = 1;
            end
            enable = ($urandom_range(0, 2) != 0);
            if (!busy && pend == 0 && acc_next == 0) break;
        end
        check("bp_drained", busy, 0);
        enable = 1'b1;
        for (int i = 0; i < 4; i++) sample();
        compare_writes("bp");

        // Reset mid-line with a second command still queued
        got_q.delete(); got_cyc.delete(); exp_q.delete();
        push_cmd(0, 200, 600, 210, 'h99);
        for (int i = 0; i < 20; i++) sample();
        push_cmd(1, 1, 2, 2, 'hAA);
        for (int i = 0; i < 3; i++) sample();
        check("pre_rst_writing", got_q.size() > 10, 1);
        #5 rst = 1'b1;
        #1;
        check("midrst_ce_released", sram_ce_n, 1);
        check("midrst_oe_released", sram_oe_n, 0);
        check("midrst_busy", busy, 0);
        check("midrst_ready", cmd_ready, 1);
        nrst = got_q.size();
        sample();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) sample();
        check("post_rst_idle", busy, 0);
        check("post_rst_no_writes", got_q.size(), nrst);

        // Recovery on the bottom-right corner pixel
        run_line("corner", 639, 479, 639, 479, 'hE7, e, bn, np);
        if (got_q.size() > 0)
            check("corner_addr", got_q[0] >> 18, 153599);

        check("bus_released_when_idle", zbad, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
